ahb2apb_bridge: RTL and testbench

AHB2APB_BRIDGE -- requirements
Module: ahb2apb_bridge

---
 rtl/ahb2apb_bridge.sv | 160 ++++++++++++++++
 tb/tb_ahb2apb_bridge.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB4 master bridge, one outstanding transfer at a time.
// Latency: reads complete 3 cycles after the address phase, writes 4; each pready=0 ACCESS cycle adds one.
// Backpressure: hreadyout stays low until the APB access completes; pready=0 stretches ACCESS indefinitely.
// Optional: define AHB2APB_PSLVERR_EN to map pslverr onto a two-cycle AHB ERROR response.
module ahb2apb_bridge #(
  parameter int AWIDTH = 16,
  parameter int DWIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  // AHB-Lite slave
  input  logic                hsel,
  input  logic [AWIDTH-1:0]   haddr,
  input  logic [1:0]          htrans,
  input  logic                hwrite,
  input  logic [2:0]          hsize,
  input  logic [DWIDTH-1:0]   hwdata,
  input  logic                hready,
  output logic                hreadyout,
  output logic [DWIDTH-1:0]   hrdata,
  output logic [1:0]          hresp,
  // APB4 master
  output logic [AWIDTH-1:0]   paddr,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [DWIDTH-1:0]   pwdata,
  output logic [DWIDTH/8-1:0] pstrb,
  input  logic                pready,
  input  logic [DWIDTH-1:0]   prdata,
  input  logic                pslverr
);

  localparam int SW = DWIDTH / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t        state;
  logic          accept;
  logic [SW-1:0] strb_nxt;
  logic          unused_inputs;

  // A new address phase is only taken when the bridge is ready to complete the previous one.
  assign accept = hsel && hready && htrans[1] && ((state == ST_IDLE) || (state == ST_ERR2));

  // Byte-lane strobes derived from the AHB size/address of the incoming transfer.
  always_comb begin
    strb_nxt = '0;
    if (hwrite) begin
      case (hsize)
        3'd0:    strb_nxt = SW'(4'b0001) << haddr[1:0];
        3'd1:    strb_nxt = SW'(4'b0011) << {haddr[1], 1'b0};
        default: strb_nxt = '1;
      endcase
    end
  end

`ifdef AHB2APB_PSLVERR_EN
  logic [1:0] hresp_q;
  assign hresp         = hresp_q;
  assign unused_inputs = htrans[0];
`else
  // Errors are never reported in this build: the response is permanently OKAY.
  assign hresp         = 2'b00;
  assign unused_inputs = htrans[0] ^ pslverr;
`endif

  // Transfer sequencer; every bus-facing output is registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hreadyout <= 1'b1;
      hrdata    <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
`ifdef AHB2APB_PSLVERR_EN
      hresp_q   <= 2'b00;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_ERR2: begin
          if (accept) begin
            paddr     <= haddr;
            pwrite    <= hwrite;
            pstrb     <= strb_nxt;
            hreadyout <= 1'b0;
`ifdef AHB2APB_PSLVERR_EN
            hresp_q   <= 2'b00;
`endif
            if (hwrite) begin
              // Write data arrives one cycle later, in the AHB data phase.
              state <= ST_WDATA;
            end else begin
              state <= ST_SETUP;
              psel  <= 1'b1;
            end
          end else begin
            state     <= ST_IDLE;
            hreadyout <= 1'b1;
`ifdef AHB2APB_PSLVERR_EN
            hresp_q   <= 2'b00;
`endif
          end
        end
        ST_WDATA: begin
          pwdata <= hwdata;
          psel   <= 1'b1;
          state  <= ST_SETUP;
        end
        ST_SETUP: begin
          penable <= 1'b1;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready) begin
            psel    <= 1'b0;
            penable <= 1'b0;
`ifdef AHB2APB_PSLVERR_EN
            if (pslverr) begin
              // First ERROR cycle keeps hreadyout low, as AHB requires.
              hresp_q <= 2'b01;
              state   <= ST_ERR1;
            end else begin
              if (!pwrite) hrdata <= prdata;
              hreadyout <= 1'b1;
              state     <= ST_IDLE;
            end
`else
            if (!pwrite) hrdata <= prdata;
            hreadyout <= 1'b1;
            state     <= ST_IDLE;
`endif
          end
        end
        ST_ERR1: begin
          hreadyout <= 1'b1;
          state     <= ST_ERR2;
        end
        default: begin
          state     <= ST_IDLE;
          hreadyout <= 1'b1;
          psel      <= 1'b0;
          penable   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Self-checking bench for ahb2apb_bridge: reset, directed table, corner sequences, random transfers.
// Expected values come from the vector table or from a transaction-level model of the bridge.
// An APB slave model inside the bench inserts the requested number of wait states.
module tb_ahb2apb_bridge;

`ifdef AHB2APB_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel;
  logic [15:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic [31:0] hrdata;
  logic [1:0]  hresp;
  logic [15:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  int n_vec = 0;
  int n_err = 0;

  ahb2apb_bridge #(.AWIDTH(16), .DWIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hwdata(hwdata), .hready(hready), .hreadyout(hreadyout), .hrdata(hrdata), .hresp(hresp),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          hwrite;
    logic [15:0] haddr;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [31:0] prdata;
    int          waits;
    bit          slverr;
    logic [3:0]  exp_strb;
    int          exp_low;   // hreadyout-low cycles for an OKAY completion
    logic [31:0] exp_rdata;
  } xfer_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Transaction-level model: byte lanes from size and address offset.
  function automatic logic [3:0] model_strb(bit w, logic [15:0] a, logic [2:0] s);
    int lane;
    lane = int'(a) % 4;
    if (!w) return 4'h0;
    if (s == 3'd0) return 4'(1 << lane);
    if (s == 3'd1) return 4'(3 << ((lane / 2) * 2));
    return 4'hF;
  endfunction

  // Wait cycles: optional data phase, one SETUP, one ACCESS per pready sample.
  function automatic int model_low(bit w, int waits);
    return (w ? 1 : 0) + 1 + waits + 1;
  endfunction

  // Drives one AHB transfer starting in the current cycle and plays the APB slave.
  task automatic run_xfer(input xfer_t v, input string tag);
    int          low, setup_n, acc_n, exp_low;
    bit          done, captured, stable, err_exp;
    logic [1:0]  last_low_resp, done_resp;
    logic        t1_psel, t1_rdy, done_psel;
    logic [15:0] cap_addr;
    logic        cap_w;
    logic [3:0]  cap_strb;
    logic [31:0] cap_wd;
    err_exp = ERR_EN && v.slverr;
    exp_low = v.exp_low + (err_exp ? 1 : 0);
    hsel = 1'b1; htrans = 2'b10; hready = 1'b1;
    haddr = v.haddr; hwrite = v.hwrite; hsize = v.hsize;
    hwdata = $urandom; pready = 1'b0; pslverr = 1'b0;
    tick();
    hsel = 1'b0; htrans = 2'b00; haddr = 16'($urandom); hwrite = 1'($urandom);
    hsize = 3'($urandom); hwdata = v.hwdata;
    t1_psel = psel; t1_rdy = hreadyout;
    low = 0; setup_n = 0; acc_n = 0; done = 0; captured = 0; stable = 1;
    last_low_resp = 2'b00; done_resp = 2'b00; done_psel = 1'b0;
    cap_addr = '0; cap_w = 1'b0; cap_strb = '0; cap_wd = '0;
    for (int c = 0; c < 100 && !done; c++) begin
      if (hreadyout) begin
        done = 1; done_resp = hresp; done_psel = psel;
      end else begin
        low++;
        last_low_resp = hresp;
        pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
        if (psel) begin
          if (!captured) begin
            captured = 1; cap_addr = paddr; cap_w = pwrite; cap_strb = pstrb; cap_wd = pwdata;
          end else if (paddr !== cap_addr || pwrite !== cap_w || pstrb !== cap_strb || pwdata !== cap_wd) begin
            stable = 0;
          end
          if (penable) begin
            pready = (acc_n == v.waits);
            pslverr = v.slverr && pready;
            if (pready) prdata = v.prdata;
            acc_n++;
          end else begin
            setup_n++;
          end
        end
        tick();
        hwdata = $urandom;
      end
    end
    pready = 1'b0; pslverr = 1'b0;
    chk({tag, " completed"}, 32'(done), 32'd1);
    chk({tag, " hreadyout_T1"}, 32'(t1_rdy), 32'd0);
    chk({tag, " psel_T1"}, 32'(t1_psel), 32'(!v.hwrite));
    chk({tag, " wait_cycles"}, 32'(low), 32'(exp_low));
    chk({tag, " hresp_done"}, 32'(done_resp), err_exp ? 32'd1 : 32'd0);
    chk({tag, " hresp_last_wait"}, 32'(last_low_resp), err_exp ? 32'd1 : 32'd0);
    chk({tag, " psel_done"}, 32'(done_psel), 32'd0);
    chk({tag, " paddr"}, 32'(cap_addr), 32'(v.haddr));
    chk({tag, " pwrite"}, 32'(cap_w), 32'(v.hwrite));
    chk({tag, " pstrb"}, 32'(cap_strb), 32'(v.exp_strb));
    chk({tag, " setup_cycles"}, 32'(setup_n), 32'd1);
    chk({tag, " access_cycles"}, 32'(acc_n), 32'(v.waits + 1));
    chk({tag, " apb_stable"}, 32'(stable), 32'd1);
    if (v.hwrite) chk({tag, " pwdata"}, cap_wd, v.hwdata);
    else if (!err_exp) chk({tag, " hrdata"}, hrdata, v.exp_rdata);
  endtask

  xfer_t tbl[10];
  xfer_t rv;
  bit    seen;

  initial begin
    // hwrite, haddr, hsize, hwdata, prdata, waits, slverr, exp_strb, exp_low, exp_rdata
    tbl[0] = '{1'b0, 16'h0010, 3'd2, 32'h0, 32'hDEADBEEF, 0, 1'b0, 4'h0, 2, 32'hDEADBEEF};
    tbl[1] = '{1'b1, 16'h0023, 3'd0, 32'h000000AA, 32'h0, 0, 1'b0, 4'b1000, 3, 32'h0};
    tbl[2] = '{1'b0, 16'h0040, 3'd2, 32'h0, 32'h12345678, 3, 1'b0, 4'h0, 5, 32'h12345678};
    tbl[3] = '{1'b1, 16'h0102, 3'd1, 32'hCAFE0000, 32'h0, 0, 1'b0, 4'b1100, 3, 32'h0};
    tbl[4] = '{1'b1, 16'h0201, 3'd1, 32'h0000BEEF, 32'h0, 1, 1'b0, 4'b0011, 4, 32'h0};
    tbl[5] = '{1'b1, 16'h0300, 3'd2, 32'h89ABCDEF, 32'h0, 2, 1'b0, 4'hF, 5, 32'h0};
    tbl[6] = '{1'b1, 16'h0305, 3'd7, 32'h01020304, 32'h0, 0, 1'b0, 4'hF, 3, 32'h0};
    tbl[7] = '{1'b1, 16'h0011, 3'd0, 32'h00005500, 32'h0, 0, 1'b0, 4'b0010, 3, 32'h0};
    tbl[8] = '{1'b1, 16'h0050, 3'd2, 32'h55AA55AA, 32'h0, 0, 1'b1, 4'hF, 3, 32'h0};
    tbl[9] = '{1'b0, 16'h0060, 3'd2, 32'h0, 32'h0BADF00D, 1, 1'b1, 4'h0, 3, 32'h0BADF00D};

    rst_n = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2;
    hwdata = '0; hready = 1'b1; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    tick(); tick();
    chk("rst hreadyout", 32'(hreadyout), 32'd1);
    chk("rst hresp", 32'(hresp), 32'd0);
    chk("rst hrdata", hrdata, 32'd0);
    chk("rst psel", 32'(psel), 32'd0);
    chk("rst penable", 32'(penable), 32'd0);
    chk("rst pwrite", 32'(pwrite), 32'd0);
    chk("rst paddr", 32'(paddr), 32'd0);
    chk("rst pwdata", pwdata, 32'd0);
    chk("rst pstrb", 32'(pstrb), 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed table, issued back to back (each address phase in the prior completion cycle).
    for (int i = 0; i < 10; i++) run_xfer(tbl[i], $sformatf("tbl%0d", i));

    // Address phases that must be ignored: hsel low, hready low, IDLE and BUSY transfers.
    hsel = 1'b0; htrans = 2'b10; hready = 1'b1; hwrite = 1'b0; haddr = 16'h0070;
    tick(); chk("ign hsel0 psel", 32'(psel), 32'd0);
    hsel = 1'b1; hready = 1'b0;
    tick(); chk("ign hready0 psel", 32'(psel), 32'd0);
    chk("ign hready0 hreadyout", 32'(hreadyout), 32'd1);
    hready = 1'b1; htrans = 2'b00;
    tick(); chk("ign idle psel", 32'(psel), 32'd0);
    htrans = 2'b01;
    tick(); chk("ign busy psel", 32'(psel), 32'd0);
    chk("ign busy hreadyout", 32'(hreadyout), 32'd1);
    hsel = 1'b0; htrans = 2'b00;
    tick();

    // Reset asserted during ACCESS abandons the transfer.
    hsel = 1'b1; htrans = 2'b10; hready = 1'b1; hwrite = 1'b0; haddr = 16'h0080;
    tick();
    hsel = 1'b0; htrans = 2'b00; pready = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (psel && penable) seen = 1;
      else tick();
    end
    chk("rstmid reached access", 32'(seen), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("rstmid psel", 32'(psel), 32'd0);
    chk("rstmid penable", 32'(penable), 32'd0);
    chk("rstmid hreadyout", 32'(hreadyout), 32'd1);
    chk("rstmid hresp", 32'(hresp), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rstmid psel after", 32'(psel), 32'd0);
    rv = '{1'b0, 16'h0090, 3'd2, 32'h0, 32'hA5A55A5A, 0, 1'b0, 4'h0, 2, 32'hA5A55A5A};
    run_xfer(rv, "post_rst");

    // Random transfers against the transaction model, sometimes separated by ignored phases.
    for (int i = 0; i < 40; i++) begin
      rv.hwrite = 1'($urandom_range(0, 1));
      rv.haddr = 16'($urandom);
      rv.hsize = 3'($urandom_range(0, 7));
      rv.hwdata = $urandom;
      rv.prdata = $urandom;
      rv.waits = $urandom_range(0, 3);
      rv.slverr = ($urandom_range(0, 3) == 0);
      rv.exp_strb = model_strb(rv.hwrite, rv.haddr, rv.hsize);
      rv.exp_low = model_low(rv.hwrite, rv.waits);
      rv.exp_rdata = rv.prdata;
      run_xfer(rv, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 2) == 0) begin
        hsel = 1'b1; htrans = 2'b10; hready = 1'b0;
        tick();
        chk($sformatf("rnd%0d gap psel", i), 32'(psel), 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
